logic_function_exerciser: RTL
=============================

Name: logic_function_exerciser

Overview:
- Sequential self-checking stimulus driver and response checker for the 3-input lab circuit F = A(B+C).
- Steps A, B, C through all 8 input combinations and waits a programmable settle time per vector.
- Samples the circuit's F output and compares it to the golden value A&(B|C).
- Reports the error count, the first failing vector and an overall pass/fail.
- Sits on the opposite side of the A/B/C/F interface from the gate-level or data-flow circuit under test: it drives the circuit's inputs and receives its output.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before F is sampled; legal range 1..15.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to run one full 8-vector sweep.
- f_in  input  1  F output of the circuit under test.
- a_out  output  1  drives circuit input A (vector bit 2).
- b_out  output  1  drives circuit input B (vector bit 1).
- c_out  output  1  drives circuit input C (vector bit 0).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or rst.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  4  number of mismatching vectors in the last or current sweep, 0..8.
- first_fail_vec  output  3  {A,B,C} of the first mismatching vector.
- first_fail_valid  output  1  high once first_fail_vec holds a captured value.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE; vec=0, settle counter=0.
  - a_out/b_out/c_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
  - rst takes priority over start and over every state; reset mid-sweep aborts the sweep with no partial result kept.
- States: IDLE, SETTLE, SAMPLE, DONE.
- Start acceptance:
  - IDLE or DONE, start=1: next cycle enters SETTLE.
  - On acceptance: vec=0, settle counter=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0, busy=1.
  - start while busy (SETTLE or SAMPLE) is ignored.
- Output drive: {a_out,b_out,c_out} = vec (registered). Outputs hold their value through SETTLE and SAMPLE and change only on the vec increment.
- SETTLE: counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle): compare f_in against expected = vec[2] & (vec[1] | vec[0]).
  - On mismatch, err_count increments.
  - On mismatch with first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec==7: go to DONE, busy=0, done=1.
  - Otherwise: vec increments, counter clears, return to SETTLE.
- Expected F truth table, vec 0..7: 0,0,0,0,0,1,1,1.
- Latency: exactly 8*(SETTLE_CYCLES+1) cycles from the start-accept edge to done rising. With SETTLE_CYCLES=2 this is 24 cycles.
- DONE:
  - Outputs and results hold; {a_out,b_out,c_out} stay at 3'b111.
  - done and pass are level signals, not pulses.
- Counter widths:
  - err_count cannot exceed 8 and never wraps.
  - vec wrap 7->0 never occurs inside a sweep, because exit happens at vec==7.
- f_in is treated as already synchronous to clk; no synchroniser is included.

Test Plan:
- Correct circuit connected (F=A&(B|C)), SETTLE_CYCLES=2, pulse start -> done=1 exactly 24 cycles later, err_count=0, pass=1, first_fail_valid=0; a/b/c observed as 000..111, each held 3 cycles.
- f_in stuck at 0 -> err_count=3, first_fail_vec=3'b101, first_fail_valid=1, pass=0.
- f_in stuck at 1 -> err_count=5, first_fail_vec=3'b000, pass=0.
- Faulty circuit F=A&B&C -> err_count=2 (vectors 101 and 110), first_fail_vec=3'b101.
- Start pulsed again at cycle 10 of a sweep -> ignored, done still at cycle 24. Start in DONE -> err_count/done/first_fail_valid clear the next cycle and a new 24-cycle sweep runs.
- rst asserted at cycle 15 of a sweep with f_in stuck at 0 -> next cycle all outputs at reset values, busy=0, and no sweep resumes without start.

Source files
------------

// File: rtl/logic_function_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : logic_function_exerciser
//  Description : Sweeps A/B/C through all 8 combinations, waits a settle time
//                per vector, samples the circuit's F output and checks it
//                against A&(B|C). Reports error count, first failing vector
//                and an overall pass flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_function_exerciser #(
    parameter int SETTLE_CYCLES = 2     // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter value on the final settle cycle of a vector.
    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] C_LAST_VEC    = 3'd7;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_vec, w_vec_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_err, w_err_nxt;
    logic [2:0] r_ff_vec, w_ff_vec_nxt;
    logic       r_ff_valid, w_ff_valid_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;

    logic       w_expected;
    logic       w_mismatch;

    // Golden response for the vector currently applied: F = A & (B | C).
    assign w_expected = r_vec[2] & (r_vec[1] | r_vec[0]);
    assign w_mismatch = (f_in != w_expected);

    // Next-state and next-result logic; every register holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_vec_nxt      = r_vec;
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = r_err;
        w_ff_vec_nxt   = r_ff_vec;
        w_ff_valid_nxt = r_ff_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_SETTLE;
                    w_vec_nxt      = 3'd0;
                    w_cnt_nxt      = 4'd0;
                    w_err_nxt      = 4'd0;
                    w_ff_vec_nxt   = 3'd0;
                    w_ff_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                end
            end
            S_SETTLE: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == C_SETTLE_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // At most 8 samples per sweep, so the 4-bit count cannot wrap.
                if (w_mismatch) begin
                    w_err_nxt = r_err + 4'd1;
                    if (!r_ff_valid) begin
                        w_ff_vec_nxt   = r_vec;
                        w_ff_valid_nxt = 1'b1;
                    end
                end
                if (r_vec == C_LAST_VEC) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_vec_nxt   = r_vec + 3'd1;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep and clears results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vec      <= 3'd0;
            r_cnt      <= 4'd0;
            r_err      <= 4'd0;
            r_ff_vec   <= 3'd0;
            r_ff_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_ff_vec   <= w_ff_vec_nxt;
            r_ff_valid <= w_ff_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign a_out            = r_vec[2];
    assign b_out            = r_vec[1];
    assign c_out            = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_done & (r_err == 4'd0);
    assign err_count        = r_err;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;

endmodule
`default_nettype wire
